ps2_ascii_tx: RTL and testbench
===============================

Name: ps2_ascii_tx

Overview:
- Inverse of the keyboard decode path: accepts one ASCII/control code per handshake, maps it to a PS/2 Set-2 scan code, and transmits the full make-then-break sequence as device-side PS/2 frames.
- Emulates a keyboard for loopback testing and for driving the host-side receiver and decoder chain.
- Owns generation of both PS/2 clock and data lines.

Parameters:
- CLK_DIV, 2500: clk cycles per PS/2 clock half-period (50 MHz gives 10 kHz); legal range ≥2.
- GAP_CYCLES, 5000: idle cycles, with both lines high, between consecutive bytes of a sequence.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ascii_in  in  8  code to send.
- ascii_valid  in  1  ascii_in is valid.
- ascii_ready  out  1  block can accept a code.
- ps2_clk_o  out  1  PS/2 clock level; idle 1.
- ps2_data_o  out  1  PS/2 data level; idle 1.
- busy  out  1  a sequence is in progress.
- unknown  out  1  one-cycle pulse when an accepted code has no mapping.

Behaviour:
- Reset: ps2_clk_o=1, ps2_data_o=1, ascii_ready=0 during rst and 1 on the first cycle after, busy=0, unknown=0. FSM goes to IDLE; any in-progress sequence is discarded. This applies mid-frame too: lines return high on the next edge.
- Handshake: accept on the cycle where ascii_valid && ascii_ready. ascii_ready=1 only in IDLE. busy = (state != IDLE).
- FSM states: IDLE -> LOOKUP -> FRAME -> GAP -> FRAME ... -> IDLE.
- LOOKUP (1 cycle):
  - Registers the scan code and the extended flag.
  - Builds the byte list: non-extended {code, F0, code}; extended {E0, code, E0, F0, code}.
  - Unmapped code: pulse unknown, send nothing, return to IDLE. ascii_ready is high again 2 cycles after the accept.
- Mapping (decided, one entry per code):
  - 0x30-0x39 map to the digit row.
  - 0x41-0x5A and 0x61-0x7A map to letters (case-folded; no shift is sent).
  - Punctuation ` - = [ ] \ ; ' , . / maps to 0E 4E 55 54 5B 5D 4C 52 41 49 4A.
  - 0x0D -> 5A; 0x08 -> 66.
  - F-keys: 0x20 -> 05, 0x21 -> 06, 0x22 -> 04, 0x23 -> 0C, 0x25 -> 03, 0x26 -> 0B, 0x28 -> 0A.
  - Arrows, extended: 0x10 -> 75, 0x11 -> 74, 0x12 -> 6B, 0x13 -> 72.
  - 0x27 maps to apostrophe (52), not F7.
  - Everything else is unmapped, including 0x2A.
- FRAME:
  - 11 bits: start 0, data[0..7] LSB first, odd parity, stop 1.
  - Each bit takes 2*CLK_DIV cycles. ps2_data_o updates on the first cycle of the bit. ps2_clk_o is high for CLK_DIV cycles, then low for CLK_DIV cycles (host samples on the falling edge).
  - The start bit drives data low on the cycle after LOOKUP.
  - Frame length is exactly 22*CLK_DIV cycles; ps2_clk_o ends high.
- GAP: GAP_CYCLES cycles with both lines high, then the next byte. After the last byte's gap, go to IDLE.
- Counters:
  - Half-period counter ceil(log2(CLK_DIV)) bits.
  - Bit index 0..10.
  - Byte index 0..4; wraps to 0 on IDLE.
- ascii_valid while busy is ignored (not queued).

Optional Feature:
- PS2_INHIBIT_SENSE_EN adds input ps2_clk_i (line sense), passed through a 2-FF synchronizer.
- Host inhibit is synchronized ps2_clk_i=0 while ps2_clk_o=1.
  - In GAP: hold and do not start the next byte.
  - In FRAME before the parity bit: abort, release both lines high, wait for release plus GAP_CYCLES, then retransmit the current byte from its start bit.
  - From the parity bit onward: complete the frame.
- Without the macro: no ps2_clk_i port and no abort logic.

Decomposition:
- Package ps2_pkg:
  - Constants for the E0 prefix and F0 break code.
  - FSM state enum.
  - Frame length constant of 11.
  - The ASCII-to-scan-code lookup as a function returning {valid, extended, code[7:0]}.
- Sub-module ps2_frame_tx: serializes one byte.
  - Inputs: start, byte.
  - Outputs: clk, data, done.
  - Parameter: CLK_DIV.
- The top level owns the handshake, lookup, byte sequencing and gap.

Test Plan (CLK_DIV=4, GAP_CYCLES=8):
- ascii 0x41: bytes 1C, F0, 1C. Frame 1 data sampled at falling edges is 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Each frame is 88 cycles; gaps are 8 cycles. ascii_ready returns after the last gap.
- ascii 0x61: identical bit stream to 0x41.
- ascii 0x10: bytes E0, 75, E0, F0, 75. F0 parity bit is 1; 75 parity bit is 0.
- ascii 0x2A: unknown pulses once. ps2_clk_o never toggles. ascii_ready is back 2 cycles after the accept.
- Hold ascii_valid=1 with 0x0D then 0x08 during busy: only 0x0D is sent (5A, F0, 5A). 0x08 is accepted only once ascii_ready=1.
- Assert rst at bit 4 of the first frame: next cycle both lines are 1 and busy=0. No further clock edges occur. A new 0x30 sends 45, F0, 45 correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: protocol byte constants, FSM states, frame length
// and the ASCII-to-Set-2 scan code table used by ps2_ascii_tx.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;   // extended-key prefix
    localparam logic [7:0] SC_BREAK = 8'hF0;   // break (key release) code
    localparam int         FRAME_BITS = 11;    // start + 8 data + parity + stop

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FRAME,
        GAP
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic [7:0] code;
    } scan_t;

    // Returns {valid, extended, code}; lower-case letters fold onto upper case.
    function automatic scan_t ascii_to_scan(input logic [7:0] a);
        scan_t      r;
        logic [7:0] f;
        r = '{valid: 1'b1, ext: 1'b0, code: 8'h00};
        f = (a >= 8'h61 && a <= 8'h7A) ? (a & 8'hDF) : a;
        case (f)
            8'h30: r.code = 8'h45;  8'h31: r.code = 8'h16;
            8'h32: r.code = 8'h1E;  8'h33: r.code = 8'h26;
            8'h34: r.code = 8'h25;  8'h35: r.code = 8'h2E;
            8'h36: r.code = 8'h36;  8'h37: r.code = 8'h3D;
            8'h38: r.code = 8'h3E;  8'h39: r.code = 8'h46;
            8'h41: r.code = 8'h1C;  8'h42: r.code = 8'h32;
            8'h43: r.code = 8'h21;  8'h44: r.code = 8'h23;
            8'h45: r.code = 8'h24;  8'h46: r.code = 8'h2B;
            8'h47: r.code = 8'h34;  8'h48: r.code = 8'h33;
            8'h49: r.code = 8'h43;  8'h4A: r.code = 8'h3B;
            8'h4B: r.code = 8'h42;  8'h4C: r.code = 8'h4B;
            8'h4D: r.code = 8'h3A;  8'h4E: r.code = 8'h31;
            8'h4F: r.code = 8'h44;  8'h50: r.code = 8'h4D;
            8'h51: r.code = 8'h15;  8'h52: r.code = 8'h2D;
            8'h53: r.code = 8'h1B;  8'h54: r.code = 8'h2C;
            8'h55: r.code = 8'h3C;  8'h56: r.code = 8'h2A;
            8'h57: r.code = 8'h1D;  8'h58: r.code = 8'h22;
            8'h59: r.code = 8'h35;  8'h5A: r.code = 8'h1A;
            8'h60: r.code = 8'h0E;  8'h2D: r.code = 8'h4E;
            8'h3D: r.code = 8'h55;  8'h5B: r.code = 8'h54;
            8'h5D: r.code = 8'h5B;  8'h5C: r.code = 8'h5D;
            8'h3B: r.code = 8'h4C;  8'h27: r.code = 8'h52;  // apostrophe wins over F7
            8'h2C: r.code = 8'h41;  8'h2E: r.code = 8'h49;
            8'h2F: r.code = 8'h4A;
            8'h0D: r.code = 8'h5A;  8'h08: r.code = 8'h66;
            8'h20: r.code = 8'h05;  8'h21: r.code = 8'h06;
            8'h22: r.code = 8'h04;  8'h23: r.code = 8'h0C;
            8'h25: r.code = 8'h03;  8'h26: r.code = 8'h0B;
            8'h28: r.code = 8'h0A;
            8'h10: begin r.code = 8'h75; r.ext = 1'b1; end
            8'h11: begin r.code = 8'h74; r.ext = 1'b1; end
            8'h12: begin r.code = 8'h6B; r.ext = 1'b1; end
            8'h13: begin r.code = 8'h72; r.ext = 1'b1; end
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_ascii_tx_if.sv
// Code handshake between a producer (master) and ps2_ascii_tx (slave).
interface ps2_ascii_tx_if;
    logic [7:0] ascii_in;
    logic       ascii_valid;
    logic       ascii_ready;

    modport master (output ascii_in, output ascii_valid, input ascii_ready);
    modport slave  (input ascii_in, input ascii_valid, output ascii_ready);
endinterface

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit device-side PS/2 frame. Each bit lasts
// 2*CLK_DIV cycles: clock high for CLK_DIV, then low for CLK_DIV.
// With PS2_INHIBIT_SENSE_EN defined, adds an abort input and a bit index output.
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst,
`ifdef PS2_INHIBIT_SENSE_EN
    input  logic       abort,
    output logic [3:0] bit_num,
`endif
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       done
);

    localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [7:0]       byte_q;
    logic [3:0]       bit_q;
    logic [CNT_W-1:0] cnt_q;
    logic             low_q;
    logic             active_q;
    logic             clk_q;
    logic             data_q;
    logic             half_end;
    logic             last_bit;

    // Line level for bit position idx: start 0, data LSB first, odd parity, stop 1.
    function automatic logic bit_value(input logic [7:0] b, input logic [3:0] idx);
        case (idx)
            4'd0:                                    return 1'b0;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:                  return b[idx - 4'd1];
            4'd9:                                    return ~^b;
            default:                                 return 1'b1;
        endcase
    endfunction

    assign half_end = (cnt_q == CNT_LAST);
    assign last_bit = (bit_q == 4'(FRAME_BITS - 1));
    assign done     = active_q && low_q && half_end && last_bit;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;
`ifdef PS2_INHIBIT_SENSE_EN
    assign bit_num  = bit_q;
`endif

    // Bit timing and line drivers; lines idle high whenever no frame is active.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q   <= '0;
            bit_q    <= '0;
            cnt_q    <= '0;
            low_q    <= 1'b0;
            active_q <= 1'b0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
`ifdef PS2_INHIBIT_SENSE_EN
        end else if (abort) begin
            active_q <= 1'b0;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
`endif
        end else if (start) begin
            byte_q   <= tx_byte;
            bit_q    <= '0;
            cnt_q    <= '0;
            low_q    <= 1'b0;
            active_q <= 1'b1;
            clk_q    <= 1'b1;
            data_q   <= 1'b0;
        end else if (active_q) begin
            if (half_end) begin
                cnt_q <= '0;
                if (!low_q) begin
                    low_q <= 1'b1;
                    clk_q <= 1'b0;
                end else if (last_bit) begin
                    active_q <= 1'b0;
                    clk_q    <= 1'b1;
                    data_q   <= 1'b1;
                end else begin
                    bit_q  <= bit_q + 4'd1;
                    low_q  <= 1'b0;
                    clk_q  <= 1'b1;
                    data_q <= bit_value(byte_q, bit_q + 4'd1);
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_ascii_tx.sv
// Keyboard emulator: accepts one ASCII/control code, looks up its Set-2 scan
// code and transmits make-then-break as PS/2 frames separated by idle gaps.
// Optional macro PS2_INHIBIT_SENSE_EN adds ps2_clk_i host-inhibit sensing.
module ps2_ascii_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000
) (
    input  logic           clk,
    input  logic           rst,
`ifdef PS2_INHIBIT_SENSE_EN
    input  logic           ps2_clk_i,
`endif
    ps2_ascii_tx_if.slave  host,
    output logic           ps2_clk_o,
    output logic           ps2_data_o,
    output logic           busy,
    output logic           unknown
);

    localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0]       ascii_q;
    logic [7:0]       code_q;
    logic             ext_q;
    logic [2:0]       byte_idx_q;
    logic [GAP_W-1:0] gap_q;
    scan_t            scan;
    logic             ready_c;
    logic             accept;
    logic             frame_start;
    logic             frame_done;
    logic [7:0]       tx_byte;
    logic             unknown_c;
    logic [2:0]       last_idx;
    logic             gap_hold;
    logic             retry;

    // Byte idx of the sequence: {code, F0, code} or {E0, code, E0, F0, code}.
    function automatic logic [7:0] byte_at(input logic ext, input logic [7:0] code,
                                           input logic [2:0] idx);
        if (!ext) return (idx == 3'd1) ? SC_BREAK : code;
        case (idx)
            3'd0, 3'd2: return SC_EXT;
            3'd3:       return SC_BREAK;
            default:    return code;
        endcase
    endfunction

    assign scan             = ascii_to_scan(ascii_q);
    assign ready_c          = (state_q == IDLE) && !rst;
    assign host.ascii_ready = ready_c;
    assign accept           = host.ascii_valid && ready_c;
    assign busy             = (state_q != IDLE);
    assign unknown          = unknown_c && !rst;
    assign last_idx         = ext_q ? 3'd4 : 3'd2;

`ifdef PS2_INHIBIT_SENSE_EN
    logic [1:0] clk_sync_q;
    logic       inhibit;
    logic       frame_abort;
    logic       retry_q;
    logic [3:0] bit_num;

    assign inhibit  = !clk_sync_q[1] && ps2_clk_o;
    assign gap_hold = inhibit;
    assign retry    = retry_q;

    // Two-flop synchronizer for the sensed clock line; idles high.
    always_ff @(posedge clk) begin
        if (rst) clk_sync_q <= 2'b11;
        else     clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
    end

    // Remembers an aborted frame so the gap exit resends the same byte.
    always_ff @(posedge clk) begin
        if (rst)                                      retry_q <= 1'b0;
        else if (frame_abort)                         retry_q <= 1'b1;
        else if (state_q == GAP && state_d == FRAME)  retry_q <= 1'b0;
    end
`else
    assign gap_hold = 1'b0;
    assign retry    = 1'b0;
`endif

    ps2_frame_tx #(.CLK_DIV(CLK_DIV)) u_frame (
        .clk      (clk),
        .rst      (rst),
`ifdef PS2_INHIBIT_SENSE_EN
        .abort    (frame_abort),
        .bit_num  (bit_num),
`endif
        .start    (frame_start),
        .tx_byte  (tx_byte),
        .ps2_clk  (ps2_clk_o),
        .ps2_data (ps2_data_o),
        .done     (frame_done)
    );

    // Next-state logic: handshake, lookup, byte sequencing and gap exit.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        frame_start = 1'b0;
        tx_byte     = byte_at(ext_q, code_q, byte_idx_q);
        unknown_c   = 1'b0;
`ifdef PS2_INHIBIT_SENSE_EN
        frame_abort = 1'b0;
`endif
        case (state_q)
            IDLE: if (accept) state_d = LOOKUP;
            LOOKUP: begin
                if (scan.valid) begin
                    frame_start = 1'b1;
                    tx_byte     = byte_at(scan.ext, scan.code, 3'd0);
                    state_d     = FRAME;
                end else begin
                    unknown_c = 1'b1;
                    state_d   = IDLE;
                end
            end
            FRAME: begin
`ifdef PS2_INHIBIT_SENSE_EN
                if (inhibit && bit_num < 4'd9) begin
                    frame_abort = 1'b1;
                    state_d     = GAP;
                end else
`endif
                if (frame_done) state_d = GAP;
            end
            GAP: begin
                if (gap_q == GAP_LAST && !gap_hold) begin
                    if (retry) begin
                        frame_start = 1'b1;
                        state_d     = FRAME;
                    end else if (byte_idx_q == last_idx) begin
                        state_d = IDLE;
                    end else begin
                        frame_start = 1'b1;
                        tx_byte     = byte_at(ext_q, code_q, byte_idx_q + 3'd1);
                        state_d     = FRAME;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, captured code, lookup result, gap counter and byte index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ascii_q    <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            byte_idx_q <= '0;
            gap_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) ascii_q <= host.ascii_in;
            if (state_q == LOOKUP) begin
                code_q <= scan.code;
                ext_q  <= scan.ext;
            end
            if (state_q == GAP && state_d == GAP && !gap_hold) gap_q <= gap_q + GAP_W'(1);
            else                                               gap_q <= '0;
            if (state_d == IDLE)
                byte_idx_q <= '0;
            else if (state_q == GAP && state_d == FRAME && !retry)
                byte_idx_q <= byte_idx_q + 3'd1;
        end
    end

endmodule

// File: tb/tb_ps2_ascii_tx.sv
// Scoreboard bench for ps2_ascii_tx (CLK_DIV=4, GAP_CYCLES=8): the driver
// pushes hand-computed scan bytes, a monitor decodes frames off the lines.
module tb_ps2_ascii_tx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FRAME_CYC  = 22 * CLK_DIV;
    localparam int WAIT_MAX   = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk_o, ps2_data_o, busy, unknown;

    ps2_ascii_tx_if host_if ();

    ps2_ascii_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (host_if.slave),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .busy       (busy),
        .unknown    (unknown)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Monitor state
    int   cyc = 0, end_cyc = 0, cnt = 0, nbits = 0;
    int   fall_cnt = 0, unk_cnt = 0;
    bit   in_frame = 0, pend_gap = 0, pend_ready = 0;
    logic prev_clk = 1'b1;
    logic [10:0] bits;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] b, input bit last);
        exp_t e;
        e.b = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out actual=waiting required=event", name);
    endtask

    // Monitor: samples lines on the falling clk edge, decodes frames, checks timing.
    always @(negedge clk) begin
        if (rst) begin
            in_frame   = 0;
            nbits      = 0;
            pend_gap   = 0;
            pend_ready = 0;
        end else begin
            if (unknown) unk_cnt++;
            if (!in_frame && ps2_data_o == 1'b0) begin
                in_frame = 1;
                cnt      = 0;
                nbits    = 0;
                if (pend_gap) begin
                    check("gap_len", cyc - end_cyc, GAP_CYCLES);
                    pend_gap = 0;
                end
            end else if (in_frame) begin
                cnt++;
            end
            if (prev_clk && !ps2_clk_o) begin
                fall_cnt++;
                if (in_frame && nbits < 11) begin
                    bits[nbits] = ps2_data_o;
                    nbits++;
                end
            end
            if (!prev_clk && ps2_clk_o && in_frame && nbits == 11) begin
                logic [7:0] rx;
                rx = bits[8:1];
                check("frame_len", cnt, FRAME_CYC);
                check("start_bit", bits[0], 1'b0);
                check("stop_bit", bits[10], 1'b1);
                check("parity_bit", bits[9], ~^rx);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame actual=%0h required=none", rx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_byte", rx, e.b);
                    if (e.last) pend_ready = 1;
                    else        pend_gap   = 1;
                end
                end_cyc  = cyc;
                in_frame = 0;
            end
            if (pend_ready && host_if.ascii_ready) begin
                check("ready_after_gap", cyc - end_cyc, GAP_CYCLES);
                pend_ready = 0;
            end
        end
        prev_clk = ps2_clk_o;
        cyc++;
    end

    // Presents a code until accepted; returns on the negedge after the accept edge.
    task automatic send(input logic [7:0] code, input bit hold);
        int n;
        @(negedge clk);
        host_if.ascii_in    = code;
        host_if.ascii_valid = 1'b1;
        n = 0;
        while (!host_if.ascii_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout("accept");
        @(posedge clk);
        @(negedge clk);
        if (!hold) host_if.ascii_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_ready || !host_if.ascii_ready) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout("sequence_done");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base_unk, base_fall, n;
        host_if.ascii_in    = 8'h00;
        host_if.ascii_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk", ps2_clk_o, 1'b1);
        check("rst_data", ps2_data_o, 1'b1);
        check("rst_ready", host_if.ascii_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_unknown", unknown, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", host_if.ascii_ready, 1'b1);

        // 'A' -> 1C F0 1C
        send(8'h41, 0);
        check("busy_A", busy, 1'b1);
        push_exp(8'h1C, 0); push_exp(8'hF0, 0); push_exp(8'h1C, 1);
        wait_done();

        // 'a' folds to the same key
        send(8'h61, 0);
        push_exp(8'h1C, 0); push_exp(8'hF0, 0); push_exp(8'h1C, 1);
        wait_done();

        // Up arrow, extended: E0 75 E0 F0 75
        send(8'h10, 0);
        push_exp(8'hE0, 0); push_exp(8'h75, 0); push_exp(8'hE0, 0);
        push_exp(8'hF0, 0); push_exp(8'h75, 1);
        wait_done();

        // '*' is unmapped: one unknown pulse, no clock activity
        base_unk  = unk_cnt;
        base_fall = fall_cnt;
        send(8'h2A, 0);
        check("unknown_pulse", unknown, 1'b1);
        check("ready_lookup", host_if.ascii_ready, 1'b0);
        @(negedge clk);
        check("ready_2_after", host_if.ascii_ready, 1'b1);
        check("unknown_low", unknown, 1'b0);
        repeat (20) @(negedge clk);
        check("unknown_count", unk_cnt - base_unk, 1);
        check("no_clk_unknown", fall_cnt - base_fall, 0);

        // Valid held through busy: 0x0D goes first, 0x08 waits for ready
        send(8'h0D, 1);
        push_exp(8'h5A, 0); push_exp(8'hF0, 0); push_exp(8'h5A, 1);
        host_if.ascii_in = 8'h08;
        n = 0;
        while (!host_if.ascii_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout("ready_hold");
        check("cr_done_before_bs", exp_q.size(), 0);
        @(posedge clk);
        push_exp(8'h66, 0); push_exp(8'hF0, 0); push_exp(8'h66, 1);
        @(negedge clk);
        host_if.ascii_valid = 1'b0;
        wait_done();

        // Reset during bit 4 of the first frame discards the sequence
        send(8'h41, 0);
        base_fall = fall_cnt;
        n = 0;
        while (fall_cnt < base_fall + 4 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_MAX) timeout("bit4");
        repeat (CLK_DIV + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_clk", ps2_clk_o, 1'b1);
        check("midrst_data", ps2_data_o, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", host_if.ascii_ready, 1'b0);
        rst = 1'b0;
        base_fall = fall_cnt;
        @(negedge clk);
        check("midrst_ready_after", host_if.ascii_ready, 1'b1);
        repeat (30) @(negedge clk);
        check("midrst_no_clk", fall_cnt - base_fall, 0);
        check("midrst_data_idle", ps2_data_o, 1'b1);

        // '0' after the reset -> 45 F0 45
        send(8'h30, 0);
        push_exp(8'h45, 0); push_exp(8'hF0, 0); push_exp(8'h45, 1);
        wait_done();

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
